// File: rtl/bp_pkg.sv
// Shared types and encodings for the fetch-stage branch predictor.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam logic [1:0] KIND_NONE   = 2'b00;
  localparam logic [1:0] KIND_BRANCH = 2'b01;
  localparam logic [1:0] KIND_JAL    = 2'b10;
  localparam logic [1:0] KIND_JALR   = 2'b11;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Table entry payload; the tag is kept separately because its width tracks IDX_W.
  typedef struct packed {
    logic        valid;
    logic [31:0] target;
    ctr_e        ctr;
  } bp_entry_t;

  localparam bp_entry_t RST_ENTRY = '{valid: 1'b0, target: 32'd0, ctr: CTR_WNT};

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating direction counter: step toward taken or not-taken, clamp at the ends.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    if (taken && (state != CTR_ST)) begin
      next_state = state + 2'd1;
    end else if (!taken && (state != CTR_SNT)) begin
      next_state = state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: fetch-stage lookup,
// execute-stage training, mispredict detection and a saturating mispredict counter.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        pred_taken_F,
  output logic [31:0] pred_target_F,
  input  logic [1:0]  upd_kind_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic        br_taken_E,
  input  logic [31:0] br_target_E,
  input  logic        pred_taken_E,
  input  logic [31:0] pred_target_E,
  input  logic        flush_E,
  output logic        mispredict_E,
  output logic [31:0] redirect_pc_E,
  output logic [15:0] mispred_count
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  bp_entry_t        entry_q [DEPTH];
  bp_entry_t        entry_d [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [TAG_W-1:0] tag_d   [DEPTH];
  logic [15:0]      mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  bp_entry_t        ent_f, ent_e;
  logic             hit_f, hit_e;
  logic             upd_en, taken_e;
  logic [1:0]       ctr_next;
  logic             unused_pc_bits_c;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];
  assign unused_pc_bits_c = ^{PCF[1:0], PCE[1:0]};

  // Fetch lookup reads the registered table, so same-cycle writes are not bypassed.
  always_comb begin
    ent_f         = entry_q[idx_f];
    hit_f         = ent_f.valid && (tag_q[idx_f] == tag_f);
    pred_taken_F  = hit_f && (ent_f.ctr inside {CTR_WT, CTR_ST});
    pred_target_F = ent_f.target;
  end

  assign ent_e   = entry_q[idx_e];
  assign hit_e   = ent_e.valid && (tag_q[idx_e] == tag_e);
  assign upd_en  = (upd_kind_E != KIND_NONE) && !flush_E;
  assign taken_e = (upd_kind_E == KIND_JAL) || (upd_kind_E == KIND_JALR) || br_taken_E;

  assign mispredict_E  = upd_en && ((pred_taken_E != taken_e) ||
                                    (taken_e && (pred_target_E != br_target_E)));
  assign redirect_pc_E = taken_e ? br_target_E : PCPlus4E;
  assign mispred_count = mispred_count_q;

  sat_counter2 u_ctr (
    .state      (ent_e.ctr),
    .taken      (br_taken_E),
    .next_state (ctr_next)
  );

  // Execute-stage training of the indexed entry.
  always_comb begin
    entry_d         = entry_q;
    tag_d           = tag_q;
    mispred_count_d = mispred_count_q;
    if (mispredict_E && (mispred_count_q != 16'hFFFF)) begin
      mispred_count_d = mispred_count_q + 16'd1;
    end
    if (upd_en) begin
      case (upd_kind_E)
        KIND_BRANCH: begin
          if (hit_e) begin
            entry_d[idx_e].ctr = ctr_e'(ctr_next);
            if (br_taken_E) entry_d[idx_e].target = br_target_E;
          end else if (br_taken_E) begin
            entry_d[idx_e] = '{valid: 1'b1, target: br_target_E, ctr: CTR_WT};
            tag_d[idx_e]   = tag_e;
          end
        end
        KIND_JAL: begin
          entry_d[idx_e] = '{valid: 1'b1, target: br_target_E, ctr: CTR_ST};
          tag_d[idx_e]   = tag_e;
        end
        KIND_JALR: begin
          // Indirect targets are not predictable from a single stored target.
          if (hit_e) entry_d[idx_e].valid = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q         <= '{default: RST_ENTRY};
      tag_q           <= '{default: '0};
      mispred_count_q <= 16'd0;
    end else begin
      entry_q         <= entry_d;
      tag_q           <= tag_d;
      mispred_count_q <= mispred_count_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand sequences and
// random traffic checked against an array-based reference model.
module tb_branch_predictor;
  import bp_pkg::*;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic        clk, rst_n;
  logic [31:0] PCF, PCE, PCPlus4E, br_target_E, pred_target_E;
  logic [31:0] pred_target_F, redirect_pc_E;
  logic [1:0]  upd_kind_E;
  logic        br_taken_E, pred_taken_E, flush_E;
  logic        pred_taken_F, mispredict_E;
  logic [15:0] mispred_count;

  branch_predictor #(.IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCF           (PCF),
    .pred_taken_F  (pred_taken_F),
    .pred_target_F (pred_target_F),
    .upd_kind_E    (upd_kind_E),
    .PCE           (PCE),
    .PCPlus4E      (PCPlus4E),
    .br_taken_E    (br_taken_E),
    .br_target_E   (br_target_E),
    .pred_taken_E  (pred_taken_E),
    .pred_target_E (pred_target_E),
    .flush_E       (flush_E),
    .mispredict_E  (mispredict_E),
    .redirect_pc_E (redirect_pc_E),
    .mispred_count (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: plain arrays, counter as an integer 0..3.
  bit          mv   [DEPTH];
  logic [31:0] mtag [DEPTH];
  logic [31:0] mtgt [DEPTH];
  int          mctr [DEPTH];
  int          mcnt;

  task automatic m_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      mv[i] = 1'b0; mtag[i] = 32'd0; mtgt[i] = 32'd0; mctr[i] = 1;
    end
    mcnt = 0;
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] m_tag(input logic [31:0] pc);
    return pc / (4 * DEPTH);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc, output logic [31:0] tgt);
    int i;
    i = m_idx(pc);
    tgt = mtgt[i];
    return mv[i] && (mtag[i] == m_tag(pc)) && (mctr[i] >= 2);
  endfunction

  function automatic bit m_taken(input logic [1:0] kind, input bit tk);
    return (kind == KIND_JAL) || (kind == KIND_JALR) || tk;
  endfunction

  function automatic bit m_mis(input logic [1:0] kind, input bit fl, input bit tk,
                               input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    bit eff;
    eff = m_taken(kind, tk);
    if (kind == KIND_NONE || fl) return 1'b0;
    return (ptk != eff) || (eff && (ptgt != tgt));
  endfunction

  task automatic m_update(input logic [1:0] kind, input logic [31:0] pce, input bit tk,
                          input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                          input bit fl);
    int i;
    bit hit;
    if (kind == KIND_NONE || fl) return;
    if (m_mis(kind, fl, tk, tgt, ptk, ptgt) && mcnt < 65535) mcnt++;
    i = m_idx(pce);
    hit = mv[i] && (mtag[i] == m_tag(pce));
    case (kind)
      KIND_BRANCH: begin
        if (hit) begin
          mctr[i] = tk ? ((mctr[i] < 3) ? mctr[i] + 1 : 3) : ((mctr[i] > 0) ? mctr[i] - 1 : 0);
          if (tk) mtgt[i] = tgt;
        end else if (tk) begin
          mv[i] = 1'b1; mtag[i] = m_tag(pce); mtgt[i] = tgt; mctr[i] = 2;
        end
      end
      KIND_JAL: begin
        mv[i] = 1'b1; mtag[i] = m_tag(pce); mtgt[i] = tgt; mctr[i] = 3;
      end
      default: if (hit) mv[i] = 1'b0;
    endcase
  endtask

  task automatic drive(input logic [1:0] kind, input logic [31:0] pce, input bit tk,
                       input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                       input bit fl, input logic [31:0] pcf);
    upd_kind_E = kind; PCE = pce; PCPlus4E = pce + 32'd4; br_taken_E = tk;
    br_target_E = tgt; pred_taken_E = ptk; pred_target_E = ptgt; flush_E = fl; PCF = pcf;
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] pce;
    bit          tk;
    logic [31:0] tgt;
    bit          ptk;
    logic [31:0] ptgt;
    bit          fl;
    logic [31:0] probe;
    bit          e_mis;
    logic [31:0] e_redir;
    bit          e_ptk;
    logic [31:0] e_ptgt;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] kind, input logic [31:0] pce, input bit tk,
                              input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                              input bit fl, input logic [31:0] probe, input bit e_mis,
                              input logic [31:0] e_redir, input bit e_ptk,
                              input logic [31:0] e_ptgt, input int e_cnt);
    vec_t v;
    v.kind = kind; v.pce = pce; v.tk = tk; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt;
    v.fl = fl; v.probe = probe; v.e_mis = e_mis; v.e_redir = e_redir; v.e_ptk = e_ptk;
    v.e_ptgt = e_ptgt; v.e_cnt = e_cnt;
    return v;
  endfunction

  function automatic logic [31:0] pick_pc();
    return 32'(($urandom_range(4, 7) << 6) | ($urandom_range(0, 3) << 2));
  endfunction

  task automatic rand_step();
    logic [1:0]  kind;
    logic [31:0] pce, pcf, tgt, ptgt, etgt;
    bit          tk, ptk, fl, etk;
    pce  = pick_pc();
    pcf  = pick_pc();
    kind = 2'($urandom_range(0, 3));
    tk   = 1'($urandom_range(0, 1));
    tgt  = 32'h800 + 32'($urandom_range(0, 3) << 4);
    if ($urandom_range(0, 1) == 1) begin
      ptk = m_pred(pce, ptgt);
    end else begin
      ptk  = 1'($urandom_range(0, 1));
      ptgt = 32'h800 + 32'($urandom_range(0, 3) << 4);
    end
    fl = ($urandom_range(0, 7) == 0);
    drive(kind, pce, tk, tgt, ptk, ptgt, fl, pcf);
    #3;
    etk = m_pred(pcf, etgt);
    chk("rnd_pred_taken_F", 32'(pred_taken_F), 32'(etk));
    if (etk) chk("rnd_pred_target_F", pred_target_F, etgt);
    chk("rnd_mispredict_E", 32'(mispredict_E), 32'(m_mis(kind, fl, tk, tgt, ptk, ptgt)));
    chk("rnd_redirect_pc_E", redirect_pc_E, m_taken(kind, tk) ? tgt : pce + 32'd4);
    @(posedge clk);
    m_update(kind, pce, tk, tgt, ptk, ptgt, fl);
    #1;
    chk("rnd_mispred_count", 32'(mispred_count), 32'(mcnt));
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = mk(KIND_NONE,   32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h004, 0, 32'h000, 0);
    vecs[1]  = mk(KIND_BRANCH, 32'h100, 1, 32'h180, 0, 32'h000, 0, 32'h100, 1, 32'h180, 1, 32'h180, 1);
    vecs[2]  = mk(KIND_BRANCH, 32'h100, 0, 32'h180, 1, 32'h180, 0, 32'h100, 1, 32'h104, 0, 32'h000, 2);
    vecs[3]  = mk(KIND_BRANCH, 32'h100, 0, 32'h180, 0, 32'h000, 0, 32'h100, 0, 32'h104, 0, 32'h000, 2);
    vecs[4]  = mk(KIND_BRANCH, 32'h100, 1, 32'h180, 0, 32'h000, 0, 32'h100, 1, 32'h180, 0, 32'h000, 3);
    vecs[5]  = mk(KIND_BRANCH, 32'h100, 1, 32'h180, 0, 32'h000, 0, 32'h100, 1, 32'h180, 1, 32'h180, 4);
    vecs[6]  = mk(KIND_BRANCH, 32'h100, 0, 32'h180, 1, 32'h180, 1, 32'h100, 0, 32'h104, 1, 32'h180, 4);
    vecs[7]  = mk(KIND_NONE,   32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h140, 0, 32'h004, 0, 32'h000, 4);
    vecs[8]  = mk(KIND_BRANCH, 32'h140, 1, 32'h1C0, 0, 32'h000, 0, 32'h140, 1, 32'h1C0, 1, 32'h1C0, 5);
    vecs[9]  = mk(KIND_NONE,   32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h004, 0, 32'h000, 5);
    vecs[10] = mk(KIND_JAL,    32'h200, 0, 32'h300, 0, 32'h000, 0, 32'h200, 1, 32'h300, 1, 32'h300, 6);
    vecs[11] = mk(KIND_JALR,   32'h200, 0, 32'h340, 1, 32'h300, 0, 32'h200, 1, 32'h340, 0, 32'h000, 7);
    vecs[12] = mk(KIND_JALR,   32'h200, 0, 32'h340, 0, 32'h000, 0, 32'h200, 1, 32'h340, 0, 32'h000, 8);
    vecs[13] = mk(KIND_JAL,    32'h204, 0, 32'h400, 1, 32'h400, 0, 32'h204, 0, 32'h400, 1, 32'h400, 8);
    vecs[14] = mk(KIND_BRANCH, 32'h204, 1, 32'h500, 1, 32'h400, 0, 32'h204, 1, 32'h500, 1, 32'h500, 9);
    vecs[15] = mk(KIND_BRANCH, 32'h204, 0, 32'h500, 1, 32'h500, 0, 32'h204, 1, 32'h208, 1, 32'h500, 10);

    // Reset: lookup idle, mispredict still combinational.
    rst_n = 1'b0;
    m_reset();
    drive(KIND_BRANCH, 32'h100, 1, 32'h180, 0, 32'h000, 0, 32'h100);
    #3;
    chk("rst_pred_taken_F", 32'(pred_taken_F), 32'd0);
    chk("rst_mispredict_E", 32'(mispredict_E), 32'd1);
    chk("rst_redirect_pc_E", redirect_pc_E, 32'h180);
    chk("rst_mispred_count", 32'(mispred_count), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_count", 32'(mispred_count), 32'd0);
    chk("rst_hold_pred", 32'(pred_taken_F), 32'd0);
    drive(KIND_NONE, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h100);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      drive(vecs[k].kind, vecs[k].pce, vecs[k].tk, vecs[k].tgt, vecs[k].ptk, vecs[k].ptgt,
            vecs[k].fl, vecs[k].probe);
      #3;
      chk($sformatf("v%0d_mispredict_E", k), 32'(mispredict_E), 32'(vecs[k].e_mis));
      chk($sformatf("v%0d_redirect_pc_E", k), redirect_pc_E, vecs[k].e_redir);
      @(posedge clk);
      m_update(vecs[k].kind, vecs[k].pce, vecs[k].tk, vecs[k].tgt, vecs[k].ptk, vecs[k].ptgt,
               vecs[k].fl);
      #1;
      chk($sformatf("v%0d_pred_taken_F", k), 32'(pred_taken_F), 32'(vecs[k].e_ptk));
      if (vecs[k].e_ptk) chk($sformatf("v%0d_pred_target_F", k), pred_target_F, vecs[k].e_ptgt);
      chk($sformatf("v%0d_mispred_count", k), 32'(mispred_count), 32'(vecs[k].e_cnt));
    end

    // Same-cycle lookup of the index being written sees the old entry.
    drive(KIND_BRANCH, 32'h300, 1, 32'h380, 0, 32'h000, 0, 32'h300);
    #3;
    chk("rw_same_pre_taken", 32'(pred_taken_F), 32'd0);
    chk("rw_same_mispredict", 32'(mispredict_E), 32'd1);
    @(posedge clk);
    m_update(KIND_BRANCH, 32'h300, 1, 32'h380, 0, 32'h000, 0);
    #1;
    chk("rw_next_taken", 32'(pred_taken_F), 32'd1);
    chk("rw_next_target", pred_target_F, 32'h380);
    chk("rw_count", 32'(mispred_count), 32'd11);

    repeat (2000) rand_step();

    // Mid-stream reset, then saturate the statistic with non-allocating JALR misses.
    rst_n = 1'b0;
    m_reset();
    drive(KIND_NONE, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h300);
    #1;
    chk("rst2_count", 32'(mispred_count), 32'd0);
    chk("rst2_pred_taken_F", 32'(pred_taken_F), 32'd0);
    rst_n = 1'b1;
    drive(KIND_JALR, 32'h3C0, 0, 32'h900, 0, 32'h000, 0, 32'h3C0);
    for (int n = 1; n <= 65540; n++) begin
      @(posedge clk);
      #1;
      if (n == 1)     chk("sat_first", 32'(mispred_count), 32'd1);
      if (n == 65534) chk("sat_fffe", 32'(mispred_count), 32'hFFFE);
      if (n == 65535) chk("sat_ffff", 32'(mispred_count), 32'hFFFF);
      if (n == 65540) chk("sat_hold", 32'(mispred_count), 32'hFFFF);
    end
    chk("jalr_no_alloc", 32'(pred_taken_F), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
